ccff_loader: RTL and testbench

CCFF_LOADER -- requirements
Module: ccff_loader

---
 rtl/ccff_pkg.sv | 15 +
 rtl/ccff_bit_shifter.sv | 49 ++++
 rtl/ccff_loader.sv | 151 +++++++++++++++
 tb/tb_ccff_loader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_pkg.sv
// Shared types and default widths for the configuration-chain loader.
package ccff_pkg;

   localparam int unsigned CCFF_BLOCK_W = 128;
   localparam int unsigned CCFF_LEN_W   = 24;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PRESET   = 3'd1,
      WAIT_BLK = 3'd2,
      SHIFT    = 3'd3,
      DONE     = 3'd4
   } ccff_state_e;

endpackage

// File: rtl/ccff_bit_shifter.sv
// Block shift register, bit-in-block down-counter and progclk phase toggle.
// A bit advances on the phase-1 step; blk_last_o flags the final bit of the block.
module ccff_bit_shifter
   import ccff_pkg::*;
#(
   parameter int unsigned BLOCK_W = CCFF_BLOCK_W
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               load_i,
   input  logic [BLOCK_W-1:0] blk_i,
   input  logic               step_i,
   output logic               phase_o,
   output logic               msb_o,
   output logic               blk_last_o
);

   localparam int unsigned     CNT_W    = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_W - 1);

   logic [BLOCK_W-1:0] sreg_q;
   logic [CNT_W-1:0]   left_q;
   logic               phase_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sreg_q  <= '0;
         left_q  <= '0;
         phase_q <= 1'b0;
      end else if (load_i) begin
         sreg_q  <= blk_i;
         left_q  <= LAST_IDX;
         phase_q <= 1'b0;
      end else if (step_i) begin
         phase_q <= ~phase_q;
         if (phase_q) begin
            sreg_q <= sreg_q << 1;
            if (left_q != '0) begin
               left_q <= left_q - 1'b1;
            end
         end
      end
   end

   assign phase_o    = phase_q;
   assign msb_o      = sreg_q[BLOCK_W-1];
   assign blk_last_o = (left_q == '0);

endmodule

// File: rtl/ccff_loader.sv
// Streams decrypted bitstream blocks MSB-first into a configuration flip-flop chain.
//
// state    | meaning
// IDLE     | waiting for start_i with a nonzero length
// PRESET   | pReset_o high for PRESET_CYC cycles
// WAIT_BLK | blk_ready_o high, waiting for the next block
// SHIFT    | two cycles per bit: phase 0 sets data, phase 1 pulses progclk
// DONE     | one-cycle done_o pulse
module ccff_loader
   import ccff_pkg::*;
#(
   parameter int unsigned BLOCK_W    = CCFF_BLOCK_W,
   parameter int unsigned LEN_W      = CCFF_LEN_W,
   parameter int unsigned PRESET_CYC = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [LEN_W-1:0]   chain_len_i,
   input  logic [BLOCK_W-1:0] blk_data_i,
   input  logic               blk_valid_i,
   output logic               blk_ready_o,
   output logic               progclk_o,
   output logic               pReset_o,
   output logic               data_o,
   input  logic               ccff_tail_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_o,
   output logic               tail_par_o
);

   localparam int unsigned      PRE_W    = (PRESET_CYC > 1) ? $clog2(PRESET_CYC) : 1;
   localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(PRESET_CYC - 1);

   ccff_state_e      state_q, state_d;
   logic [1:0]       rst_sync_q;
   logic             rst_int;
   logic [LEN_W-1:0] len_q;
   logic [PRE_W-1:0] pre_cnt_q;
   logic             err_q;
   logic             par_q;
   logic             phase;
   logic             msb;
   logic             blk_last;
   logic             start_ok;
   logic             blk_load;
   logic             bit_tick;

   // Assertion reaches every flop at once; release waits two clk_i edges.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rst_sync_q <= 2'b11;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b0};
      end
   end

   assign rst_int = rst_sync_q[1];

   assign start_ok = start_i && (state_q == IDLE) && (chain_len_i != '0);
   assign blk_load = (state_q == WAIT_BLK) && blk_valid_i;
   assign bit_tick = (state_q == SHIFT) && phase;

   always_ff @(posedge clk_i or posedge rst_int) begin
      if (rst_int) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_ok) state_d = PRESET;
         end
         PRESET: begin
            if (pre_cnt_q == '0) state_d = WAIT_BLK;
         end
         WAIT_BLK: begin
            if (blk_valid_i) state_d = SHIFT;
         end
         SHIFT: begin
            if (bit_tick) begin
               if (len_q <= LEN_W'(1)) begin
                  state_d = DONE;
               end else if (blk_last) begin
                  state_d = WAIT_BLK;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_int) begin
      if (rst_int) begin
         len_q     <= '0;
         pre_cnt_q <= '0;
         err_q     <= 1'b0;
         par_q     <= 1'b0;
      end else begin
         if (start_ok) begin
            len_q <= chain_len_i;
            err_q <= 1'b0;
            par_q <= 1'b0;
         end else if (start_i) begin
            err_q <= 1'b1;
         end
         if (state_q == PRESET) begin
            if (pre_cnt_q != '0) pre_cnt_q <= pre_cnt_q - 1'b1;
         end else begin
            pre_cnt_q <= PRE_LOAD;
         end
         if (bit_tick) begin
            par_q <= par_q ^ ccff_tail_i;
            if (len_q != '0) len_q <= len_q - 1'b1;
         end
      end
   end

   ccff_bit_shifter #(
      .BLOCK_W (BLOCK_W)
   ) u_shifter (
      .clk_i      (clk_i),
      .rst_i      (rst_int),
      .load_i     (blk_load),
      .blk_i      (blk_data_i),
      .step_i     (state_q == SHIFT),
      .phase_o    (phase),
      .msb_o      (msb),
      .blk_last_o (blk_last)
   );

   assign blk_ready_o = (state_q == WAIT_BLK);
   assign progclk_o   = bit_tick;
   assign pReset_o    = (state_q == PRESET);
   assign data_o      = (state_q == SHIFT) && msb;
   assign busy_o      = (state_q != IDLE);
   assign done_o      = (state_q == DONE);
   assign err_o       = err_q;
   assign tail_par_o  = par_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader: outputs sampled 1 ns after each rising clk_i edge.
module tb_ccff_loader;

   localparam int BW = 128;
   localparam int LW = 24;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          start_i;
   logic [LW-1:0] chain_len_i;
   logic [BW-1:0] blk_data_i;
   logic          blk_valid_i;
   logic          ccff_tail_i;
   logic          blk_ready_o, progclk_o, pReset_o, data_o;
   logic          busy_o, done_o, err_o, tail_par_o;

   int   ncomp = 0;
   int   nfail = 0;
   int   n_pulse = 0;
   int   n_hs = 0;
   int   n_done = 0;
   logic bitq[$];
   logic prog_prev = 1'b0;

   int           p0, b0, h0, d0, n, k;
   bit           ok;
   logic         prev;
   logic [127:0] v;
   logic [127:0] blk1, blk2;

   ccff_loader #(
      .BLOCK_W    (BW),
      .LEN_W      (LW),
      .PRESET_CYC (4)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .chain_len_i (chain_len_i),
      .blk_data_i  (blk_data_i),
      .blk_valid_i (blk_valid_i),
      .blk_ready_o (blk_ready_o),
      .progclk_o   (progclk_o),
      .pReset_o    (pReset_o),
      .data_o      (data_o),
      .ccff_tail_i (ccff_tail_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .tail_par_o  (tail_par_o)
   );

   always #5 clk_i = ~clk_i;

   // Chain-side observer: records data_o at every progclk_o rise, handshakes and done pulses.
   always @(negedge clk_i) begin
      if (progclk_o && !prog_prev) begin
         n_pulse++;
         bitq.push_back(data_o);
      end
      prog_prev = progclk_o;
      if (blk_valid_i && blk_ready_o) n_hs++;
      if (done_o) n_done++;
   end

   task automatic tick(input int cyc);
      repeat (cyc) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      ncomp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input int obs, input int exp);
      ncomp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      ncomp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] outs_vec();
      return {blk_ready_o, progclk_o, pReset_o, data_o, busy_o, done_o, err_o, tail_par_o};
   endfunction

   task automatic do_start(input int len);
      start_i     = 1'b1;
      chain_len_i = LW'(len);
      tick(1);
      start_i     = 1'b0;
      chain_len_i = '0;
   endtask

   task automatic wait_preset(output int cyc);
      cyc = 0;
      while (pReset_o && cyc < 20) begin
         cyc++;
         tick(1);
      end
   endtask

   task automatic feed(input logic [127:0] blk, output bit fed);
      int w;
      w = 0;
      while (!blk_ready_o && w < 300) begin
         tick(1);
         w++;
      end
      fed = blk_ready_o;
      if (fed) begin
         blk_valid_i = 1'b1;
         blk_data_i  = blk;
         tick(1);
         blk_valid_i = 1'b0;
      end
   endtask

   task automatic wait_done(output bit seen, output logic prog_before);
      int w;
      w = 0;
      prog_before = 1'b0;
      while (!done_o && w < 600) begin
         prog_before = progclk_o;
         tick(1);
         w++;
      end
      seen = done_o;
   endtask

   task automatic get_bits(input int start, input int cnt, output logic [127:0] bits);
      bits = '0;
      for (int i = 0; i < cnt; i++) begin
         bits = {bits[126:0], (start + i < bitq.size()) ? bitq[start + i] : 1'bx};
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rst_i       = 1'b1;
      start_i     = 1'b0;
      chain_len_i = '0;
      blk_data_i  = '0;
      blk_valid_i = 1'b0;
      ccff_tail_i = 1'b0;
      tick(3);
      chkw("reset_outputs", 128'(outs_vec()), 128'h0);
      rst_i = 1'b0;
      tick(3);
      chkw("after_release_idle", 128'(outs_vec()), 128'h0);

      // 8-bit load of 0xA5 with a 20-cycle stall in WAIT_BLK
      p0 = n_pulse; b0 = bitq.size(); h0 = n_hs; d0 = n_done;
      do_start(8);
      chk1("l8_busy", busy_o, 1'b1);
      wait_preset(n);
      chk32("l8_preset_cycles", n, 4);
      ok = 1'b1;
      repeat (20) begin
         if (!(blk_ready_o && !progclk_o && busy_o)) ok = 1'b0;
         tick(1);
      end
      chk1("stall_ready_noclk", ok, 1'b1);
      blk_valid_i = 1'b1;
      blk_data_i  = {8'hA5, 120'h0};
      tick(1);
      blk_valid_i = 1'b0;
      chk1("resume_cyc2_progclk", progclk_o, 1'b0);
      chk1("resume_cyc2_data", data_o, 1'b1);
      tick(1);
      chk1("resume_cyc3_progclk", progclk_o, 1'b1);
      wait_done(ok, prev);
      chk1("l8_done_seen", ok, 1'b1);
      chk1("l8_pulse_before_done", prev, 1'b1);
      tick(1);
      chk1("l8_done_one_cycle", done_o, 1'b0);
      chk1("l8_idle", busy_o, 1'b0);
      chk32("l8_pulses", n_pulse - p0, 8);
      chk32("l8_handshakes", n_hs - h0, 1);
      chk32("l8_done_count", n_done - d0, 1);
      get_bits(b0, 8, v);
      chkw("l8_bits", v, 128'hA5);
      chk1("l8_tail_par", tail_par_o, 1'b0);

      // zero-length request
      do_start(0);
      chk1("len0_err", err_o, 1'b1);
      chk1("len0_busy", busy_o, 1'b0);
      chk1("len0_preset", pReset_o, 1'b0);

      // 130-bit load across two blocks with a stray start mid-SHIFT
      blk1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      blk2 = {2'b10, {126{1'b1}}};
      p0 = n_pulse; b0 = bitq.size(); h0 = n_hs; d0 = n_done;
      do_start(130);
      chk1("l130_err_cleared", err_o, 1'b0);
      wait_preset(n);
      feed(blk1, ok);
      chk1("l130_blk1_fed", ok, 1'b1);
      tick(5);
      start_i     = 1'b1;
      chain_len_i = LW'(5);
      tick(1);
      start_i     = 1'b0;
      chain_len_i = '0;
      chk1("shift_start_err", err_o, 1'b1);
      chk1("shift_start_busy", busy_o, 1'b1);
      feed(blk2, ok);
      chk1("l130_blk2_fed", ok, 1'b1);
      chk32("l130_pulses_blk1", n_pulse - p0, 128);
      wait_done(ok, prev);
      chk1("l130_done_seen", ok, 1'b1);
      tick(1);
      chk32("l130_pulses", n_pulse - p0, 130);
      chk32("l130_handshakes", n_hs - h0, 2);
      chk32("l130_done_count", n_done - d0, 1);
      get_bits(b0, 128, v);
      chkw("l130_blk1_bits", v, blk1);
      get_bits(b0 + 128, 2, v);
      chkw("l130_blk2_bits", v, 128'h2);
      chk1("l130_err_sticky", err_o, 1'b1);

      // reset during the 50th bit of a 128-bit load
      p0 = n_pulse; d0 = n_done;
      do_start(128);
      wait_preset(n);
      feed({128{1'b1}}, ok);
      chk1("rst_blk_fed", ok, 1'b1);
      k = 0;
      while (!(progclk_o && (n_pulse - p0) == 49) && k < 400) begin
         tick(1);
         k++;
      end
      chk1("rst_reached_bit50", progclk_o, 1'b1);
      rst_i = 1'b1;
      #1;
      chkw("rst_outputs_zero", 128'(outs_vec()), 128'h0);
      tick(2);
      chk32("rst_no_done", n_done - d0, 0);
      rst_i = 1'b0;
      tick(3);
      p0 = n_pulse; b0 = bitq.size(); d0 = n_done;
      do_start(8);
      wait_preset(n);
      feed({8'h3C, 120'h0}, ok);
      wait_done(ok, prev);
      chk1("post_rst_done", ok, 1'b1);
      tick(1);
      chk32("post_rst_pulses", n_pulse - p0, 8);
      get_bits(b0, 8, v);
      chkw("post_rst_bits", v, 128'h3C);

      // tail parity with the chain tail tied high
      ccff_tail_i = 1'b1;
      do_start(7);
      wait_preset(n);
      feed({8'hFF, 120'h0}, ok);
      wait_done(ok, prev);
      tick(1);
      chk1("par7", tail_par_o, 1'b1);
      do_start(8);
      chk1("par_cleared_on_start", tail_par_o, 1'b0);
      wait_preset(n);
      feed({8'h00, 120'h0}, ok);
      wait_done(ok, prev);
      tick(1);
      chk1("par8", tail_par_o, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end

endmodule
